// File: rtl/alu_share_if.sv
// Request/response bundle between the two ALU requesters and alu_share_arbiter.
// resp_err exists only when ALU_ILLEGAL_OP_EN is defined.
interface alu_share_if #(
  parameter int unsigned WIDTH = 32
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req_a0;
  logic [WIDTH-1:0] req_b0;
  logic [3:0]       req_op0;
  logic [WIDTH-1:0] req_a1;
  logic [WIDTH-1:0] req_b1;
  logic [3:0]       req_op1;
  logic [1:0]       resp_valid;
  logic [1:0]       resp_ready;
  logic [WIDTH-1:0] resp_data;
  logic             resp_flag;
`ifdef ALU_ILLEGAL_OP_EN
  logic             resp_err;
`endif

  modport master (
`ifdef ALU_ILLEGAL_OP_EN
    input  resp_err,
`endif
    output req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_flag
  );

  modport slave (
`ifdef ALU_ILLEGAL_OP_EN
    output resp_err,
`endif
    input  req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1, resp_ready,
    output req_ready, resp_valid, resp_data, resp_flag
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational RV32 ALU between two requesters.
// Optional ALU_ILLEGAL_OP_EN: ops 9-15 bypass the ALU and respond with resp_err.
module alu_share_arbiter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned RESET_PRIO = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_share_if.slave       bus,
  output logic [WIDTH-1:0] alu_inp1,
  output logic [WIDTH-1:0] alu_inp2,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_signbit
);

  localparam logic RST_PRIO = 1'(RESET_PRIO);
`ifdef ALU_ILLEGAL_OP_EN
  localparam logic [3:0] OP_MAX = 4'd8;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic             owner_q, owner_d;
  logic [1:0]       resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0] resp_data_q, resp_data_d;
  logic             resp_flag_q, resp_flag_d;
  logic [WIDTH-1:0] inp1_q, inp1_d;
  logic [WIDTH-1:0] inp2_q, inp2_d;
  logic [3:0]       sel_q, sel_d;
`ifdef ALU_ILLEGAL_OP_EN
  logic             err_q, err_d;
`endif

  logic             gnt_c;
  logic [1:0]       ready_c;
  logic [WIDTH-1:0] req_a_c;
  logic [WIDTH-1:0] req_b_c;
  logic [3:0]       req_op_c;

  // Arbitration, request muxing and next-state logic
  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    owner_d      = owner_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_flag_d  = resp_flag_q;
    inp1_d       = inp1_q;
    inp2_d       = inp2_q;
    sel_d        = sel_q;
`ifdef ALU_ILLEGAL_OP_EN
    err_d        = err_q;
`endif
    ready_c      = 2'b00;

    // With both ports requesting, the priority holder wins; otherwise the lone requester
    gnt_c    = (&bus.req_valid) ? prio_q : bus.req_valid[1];
    req_a_c  = gnt_c ? bus.req_a1  : bus.req_a0;
    req_b_c  = gnt_c ? bus.req_b1  : bus.req_b0;
    req_op_c = gnt_c ? bus.req_op1 : bus.req_op0;

    case (state_q)
      ST_IDLE: begin
        if (|bus.req_valid) begin
          ready_c = gnt_c ? 2'b10 : 2'b01;
          owner_d = gnt_c;
`ifdef ALU_ILLEGAL_OP_EN
          if (req_op_c > OP_MAX) begin
            state_d      = ST_RESP;
            resp_valid_d = ready_c;
            resp_data_d  = '0;
            resp_flag_d  = 1'b0;
            err_d        = 1'b1;
          end else
`endif
          begin
            inp1_d  = req_a_c;
            inp2_d  = req_b_c;
            sel_d   = req_op_c;
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        resp_data_d  = alu_out;
        resp_flag_d  = alu_signbit;
        resp_valid_d = owner_q ? 2'b10 : 2'b01;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (bus.resp_ready[owner_q]) begin
          resp_valid_d = 2'b00;
          prio_d       = ~owner_q;
          state_d      = ST_IDLE;
`ifdef ALU_ILLEGAL_OP_EN
          err_d        = 1'b0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      prio_q       <= RST_PRIO;
      owner_q      <= 1'b0;
      resp_valid_q <= 2'b00;
      resp_data_q  <= '0;
      resp_flag_q  <= 1'b0;
      inp1_q       <= '0;
      inp2_q       <= '0;
      sel_q        <= 4'd0;
`ifdef ALU_ILLEGAL_OP_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      owner_q      <= owner_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_flag_q  <= resp_flag_d;
      inp1_q       <= inp1_d;
      inp2_q       <= inp2_d;
      sel_q        <= sel_d;
`ifdef ALU_ILLEGAL_OP_EN
      err_q        <= err_d;
`endif
    end
  end

  // req_ready is a decode of live inputs, so it is masked while reset is held
  assign bus.req_ready  = rst_n ? ready_c : 2'b00;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_flag  = resp_flag_q;
`ifdef ALU_ILLEGAL_OP_EN
  assign bus.resp_err   = err_q;
`endif
  assign alu_inp1 = inp1_q;
  assign alu_inp2 = inp2_q;
  assign alu_sel  = sel_q;

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single-cycle RV32 ALU between two requesters: port 0 is the main execute path and port 1 is the branch/compare unit.
- Round-robin arbitration with a valid/ready request handshake per port.
- Drives the ALU operand and select inputs from registers, captures the ALU result and flag, and returns them on a per-port response handshake.
- Sits between the requesters and the combinational ALU; the ALU itself is unchanged.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU.
- RESET_PRIO, 0, port holding priority after reset (0 or 1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  2  per-port request valid, bit i = port i.
- req_ready  output  2  per-port request accept; combinational.
- req_a0, req_b0  input  WIDTH  port 0 operands.
- req_op0  input  4  port 0 op; same encoding as ALU sel.
- req_a1, req_b1  input  WIDTH  port 1 operands.
- req_op1  input  4  port 1 op.
- resp_valid  output  2  per-port response valid.
- resp_ready  input  2  per-port response accept.
- resp_data  output  WIDTH  result, shared by both ports; qualified by resp_valid.
- resp_flag  output  1  captured ALU signbit flag.
- alu_inp1, alu_inp2  output  WIDTH  to ALU inp1/inp2.
- alu_sel  output  4  to ALU sel.
- alu_out  input  WIDTH  from ALU out.
- alu_signbit  input  1  from ALU signbit.

Behaviour:
- Op encoding: 0 AND, 1 OR, 2 SLT, 3 ADD, 4 SLL, 5 XOR, 6 SUB, 7 EQ-flag, 8 LT-flag; 9-15 illegal.
- Reset (async, rst_n=0) forces:
  - state IDLE; prio = RESET_PRIO;
  - req_ready = 0, resp_valid = 0;
  - resp_data = 0, resp_flag = 0;
  - alu_inp1 = 0, alu_inp2 = 0, alu_sel = 0.
- Reset mid-operation drops the in-flight op silently; no response is produced.
- IDLE:
  - req_ready[i] = 1 only for the winning port; 0 in all other states.
  - One valid only: that port wins.
  - Both valid: port == prio wins.
  - On accept: latch operands/op into alu_inp1/alu_inp2/alu_sel, record owner; -> EXEC.
- EXEC (1 cycle): the ALU evaluates the registered inputs. At the clock edge, capture alu_out -> resp_data and alu_signbit -> resp_flag; -> RESP.
- RESP:
  - resp_valid[owner] = 1; the other bit stays 0.
  - resp_data/resp_flag are held stable until the handshake completes.
  - On resp_ready[owner]: -> IDLE and prio = ~owner, i.e. the loser gets priority.
  - Backpressure of any length holds RESP; no new request is accepted while in RESP.
- Latency: accept edge at cycle 0, resp_valid high from cycle 2. Throughput is at most one op per 3 cycles.
- alu_inp1/alu_inp2/alu_sel hold their last values outside EXEC; they are not cleared.
- Flag ops (7, 8): resp_data carries whatever alu_out presents, and the requester uses resp_flag. Non-flag ops: resp_flag = captured alu_signbit, which the ALU drives to 0 for those ops.
- req_valid may drop before accept without effect; requests are not queued inside the block.

Optional Feature:
- Macro ALU_ILLEGAL_OP_EN.
- Defined:
  - An accepted op of 9-15 skips EXEC and goes IDLE -> RESP directly.
  - resp_data = 0, resp_flag = 0.
  - Extra output resp_err (1 bit) is 1 in that RESP and 0 otherwise; it resets to 0.
  - alu_* outputs are not updated for the illegal op.
- Undefined:
  - Illegal ops follow the normal EXEC path; the ALU default gives resp_data = 0.
  - No resp_err port exists.

Test Plan:
1. Reset, then port 0 sends ADD a=5, b=7 with resp_ready=1 -> req_ready[0]=1 at cycle 0; resp_valid=2'b01 at cycle 2; resp_data=12, resp_flag=0.
2. Both ports valid on the same cycle after reset (RESET_PRIO=0): port 0 SUB 10-3, port 1 EQ 4,4 -> port 0 served first (resp_data=7). Port 1 is then served (resp_flag=1, resp_valid=2'b10); prio then returns to 0.
3. Port 1 sends LT-flag a=0xFFFFFFFF, b=1 with resp_ready held 0 for 5 cycles -> resp_valid[1] stays high with resp_flag=1 stable. req_ready stays 0 despite port 0 holding valid; port 0 is accepted the cycle after the handshake.
4. rst_n asserted during EXEC of port 0 SLL 1<<4 -> all outputs 0 immediately. After release, no response for the dropped op; a new request completes normally.
5. Port 0 sends op=12:
   - With ALU_ILLEGAL_OP_EN: resp_valid at cycle 1, resp_data=0, resp_err=1, alu_sel unchanged.
   - Without: resp_valid at cycle 2, resp_data=0.
6. Back-to-back stream of alternating requests on both ports -> grants alternate 0,1,0,1 and each response matches its own port's operands (e.g. XOR 0xF0^0x0F=0xFF, OR 0x3|0x4=0x7).
